alu_muldiv_seq: RTL and testbench

Parametrised, handshaked successor to the single-cycle integer ALU.
Executes the RV32I integer ops (single-cycle path) and the RV32M multiply/divide ops (iterative multi-cycle path) behind a valid/ready interface.
Sits in the execute stage between operand select and writeback. A tag travels with each op so writeback can match results to issuing instructions.

---
 rtl/alu_muldiv_seq.sv | 146 ++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: handshaked RV32I ALU with iterative RV32M mul/div; define ALU_MULDIV_FAST_MUL_EN for a single-cycle multiplier
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [TAG_W-1:0] tag_out,
    output logic             illegal
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int SH_W  = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_out, r_hi, r_lo, r_d;
    logic [TAG_W-1:0] r_tag;
    logic [CNT_W-1:0] r_cnt;
    logic r_illegal, r_is_div, r_sel_hi, r_neg;
    logic w_accept, w_iter, w_s1, w_s2, w_n1, w_n2, w_dz, w_ovf, w_fast, w_last;
    logic [WIDTH-1:0] w_m1, w_m2, w_res, w_nhi, w_nlo, w_word, w_fin;
    logic [WIDTH:0] w_sum, w_sh, w_diff;
    logic [2*WIDTH-1:0] w_p2;
    logic [SH_W-1:0] w_amt;

    assign w_amt    = in_2[SH_W-1:0];
    assign w_dz     = in_2 == '0;
    assign w_ovf    = (in_1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&in_2);
    assign w_s1     = op inside {5'd11, 5'd12, 5'd14, 5'd16};
    assign w_s2     = op inside {5'd11, 5'd14, 5'd16};
    assign w_n1     = w_s1 & in_1[WIDTH-1];
    assign w_n2     = w_s2 & in_2[WIDTH-1];
    assign w_m1     = w_n1 ? -in_1 : in_1;
    assign w_m2     = w_n2 ? -in_2 : in_2;
    assign w_iter   = (op inside {[5'd10:5'd13]} && !w_fast) ||
                      (op inside {[5'd14:5'd17]} && !w_dz && !(w_ovf && (op == 5'd14 || op == 5'd16)));
    assign in_ready = (r_state == IDLE) || (r_state == DONE && out_ready);
    assign w_accept = in_valid && in_ready && !kill;
    assign w_last   = r_cnt == CNT_W'(WIDTH - 1);

    // one iteration: shift-add multiply on {hi,lo}, or restoring divide with remainder in hi, quotient in lo
    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
    assign w_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_diff = w_sh - {1'b0, r_d};
    assign w_nhi  = r_is_div ? (w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0]) : w_sum[WIDTH:1];
    assign w_nlo  = r_is_div ? {r_lo[WIDTH-2:0], ~w_diff[WIDTH]} : {w_sum[0], r_lo[WIDTH-1:1]};
    assign w_p2   = r_neg ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
    assign w_word = r_sel_hi ? w_nhi : w_nlo;
    assign w_fin  = r_is_div ? (r_neg ? -w_word : w_word) : (r_sel_hi ? w_p2[2*WIDTH-1:WIDTH] : w_p2[WIDTH-1:0]);

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_x1, w_x2, w_fp;
    assign w_x1   = {{WIDTH{w_n1}}, in_1};
    assign w_x2   = {{WIDTH{w_n2}}, in_2};
    assign w_fp   = w_x1 * w_x2;
    assign w_fast = 1'b1;
`else
    assign w_fast = 1'b0;
`endif

    // single-cycle results, including the divide corner cases
    always_comb begin
        w_res = '0;
        case (op)
            5'd0:  w_res = in_1 + in_2;
            5'd1:  w_res = in_1 - in_2;
            5'd2:  w_res = in_1 & in_2;
            5'd3:  w_res = in_1 | in_2;
            5'd4:  w_res = in_1 ^ in_2;
            5'd5:  w_res = in_1 << w_amt;
            5'd6:  w_res = in_1 >> w_amt;
            5'd7:  w_res = $signed(in_1) >>> w_amt;
            5'd8:  w_res = {{(WIDTH-1){1'b0}}, $signed(in_1) < $signed(in_2)};
            5'd9:  w_res = {{(WIDTH-1){1'b0}}, in_1 < in_2};
`ifdef ALU_MULDIV_FAST_MUL_EN
            5'd10: w_res = w_fp[WIDTH-1:0];
            5'd11, 5'd12, 5'd13: w_res = w_fp[2*WIDTH-1:WIDTH];
`endif
            5'd14: w_res = w_dz ? '1 : in_1;
            5'd15: w_res = '1;
            5'd16: w_res = w_dz ? in_1 : '0;
            5'd17: w_res = in_1;
            default: w_res = '0;
        endcase
    end

    // next state: kill beats acceptance, DONE drains or reloads
    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = w_iter ? BUSY : DONE;
        else if (r_state == BUSY) w_next = kill ? IDLE : (w_last ? DONE : BUSY);
        else if (r_state == DONE && (kill || out_ready)) w_next = IDLE;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // operand load on accept, iterate while busy, result on the finishing edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out     <= '0;
            r_tag     <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_d       <= '0;
            r_is_div  <= 1'b0;
            r_sel_hi  <= 1'b0;
            r_neg     <= 1'b0;
        end else if (w_accept) begin
            r_tag     <= tag_in;
            r_illegal <= op > 5'd17;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= w_m1;
            r_d       <= w_m2;
            r_is_div  <= op >= 5'd14;
            r_sel_hi  <= op inside {5'd11, 5'd12, 5'd13, 5'd16, 5'd17};
            r_neg     <= (op == 5'd16) ? w_n1 : (w_n1 ^ w_n2);
            if (!w_iter) r_out <= w_res;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            if (w_last && !kill) r_out <= w_fin;
        end
    end

    assign out_valid = r_state == DONE;
    assign out       = r_out;
    assign tag_out   = r_tag;
    assign illegal   = r_illegal;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: scoreboard bench for alu_muldiv_seq against an arithmetic reference model
module tb_alu_muldiv_seq;
    localparam int W = 32;
`ifdef ALU_MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   tag;
        logic         ill;
        int           acc;
        int           lat;
    } exp_t;

    logic clk = 0, reset = 0, in_valid = 0, kill = 0, out_ready = 1;
    logic in_ready, out_valid, illegal;
    logic [4:0] op = 0, tag_in = 0, tag_out;
    logic [W-1:0] in_1 = 0, in_2 = 0, out;
    exp_t q[$];
    int cyc = 0, n_vec = 0, n_err = 0;
    bit seen = 0;

    alu_muldiv_seq #(.WIDTH(W), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .in_1(in_1), .in_2(in_2), .tag_in(tag_in), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .tag_out(tag_out), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_out(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (o)
            5'd0: return a + b;
            5'd1: return a - b;
            5'd2: return a & b;
            5'd3: return a | b;
            5'd4: return a ^ b;
            5'd5: return a << b[4:0];
            5'd6: return a >> b[4:0];
            5'd7: begin p = sa >>> b[4:0]; return p[31:0]; end
            5'd8: return {31'b0, sa < sb};
            5'd9: return {31'b0, a < b};
            5'd10: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            5'd11: begin p = sa * sb; return p[63:32]; end
            5'd12: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
            5'd13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            5'd14: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == '1) return a;
                p = sa / sb;
                return p[31:0];
            end
            5'd15: return (b == 0) ? '1 : a / b;
            5'd16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == '1) return 0;
                p = sa % sb;
                return p[31:0];
            end
            5'd17: return (b == 0) ? a : a % b;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        if (o >= 10 && o <= 13) return FAST ? 1 : W + 1;
        if (o >= 14 && o <= 17 && b != 0 && !((o == 14 || o == 16) && a == 32'h8000_0000 && b == '1)) return W + 1;
        return 1;
    endfunction

    // monitor: latency on first sight of a result, contents on transfer
    always @(negedge clk) begin
        if (!reset) seen = 0;
        else if (out_valid) begin
            if (q.size() == 0) chk("spurious_valid", out_valid, 0);
            else begin
                if (!seen) begin
                    chk("latency", cyc - q[0].acc, q[0].lat);
                    seen = 1;
                end
                if (out_ready) begin
                    chk("result", out, q[0].res);
                    chk("tag", tag_out, q[0].tag);
                    chk("illegal", illegal, q[0].ill);
                    q.delete(0);
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] t, input bit rnd);
        int k;
        in_valid = 1; op = o; in_1 = a; in_2 = b; tag_in = t;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (k == 300) chk("accept_timeout", in_ready, 1);
        else q.push_back('{ref_out(o, a, b), t, o > 17, cyc, ref_lat(o, a, b)});
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1;
        while ((q.size() != 0 || out_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_queue", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1);
    end

    initial begin
        int c0;
        logic [4:0] o;
        logic [W-1:0] a, b;
        int r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_tag", tag_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1 reset = 1;

        c0 = cyc;
        issue(5'd0, 7, 5, 5'd1, 0);
        issue(5'd1, 3, 5, 5'd2, 0);
        issue(5'd7, 32'h8000_0000, 4, 5'd3, 0);
        chk("b2b_cycles", cyc - c0, 3);
        drain();

        issue(5'd11, 32'h8000_0000, 32'h8000_0000, 5'd4, 0);
        repeat (3) begin
            @(negedge clk);
            chk("busy_in_ready", in_ready, FAST);
        end
        @(posedge clk); #1;
        issue(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
        issue(5'd10, 32'hFFFF_FFF9, 32'h0000_0003, 5'd6, 0);
        issue(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
        drain();

        issue(5'd14, 32'hFFFF_FFF9, 2, 5'd8, 0);
        issue(5'd16, 32'hFFFF_FFF9, 2, 5'd9, 0);
        issue(5'd15, 100, 0, 5'd10, 0);
        issue(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
        issue(5'd17, 100, 7, 5'd13, 0);
        drain();

        out_ready = 0;
        issue(5'd9, 1, 32'hFFFF_FFFF, 5'd6, 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_out", out, 1);
            chk("bp_tag", tag_out, 6);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        drain();

        out_ready = 0;
        issue(5'd0, 1, 2, 5'd7, 0);
        @(posedge clk); #1 kill = 1;
        @(posedge clk); #1 kill = 0;
        q.delete(q.size() - 1);
        seen = 0;
        @(negedge clk);
        chk("kill_done_valid", out_valid, 0);
        @(posedge clk); #1 out_ready = 1;

        kill = 1; in_valid = 1; op = 0; in_1 = 3; in_2 = 4;
        @(posedge clk); #1 kill = 0; in_valid = 0;
        @(negedge clk);
        chk("kill_accept_valid", out_valid, 0);
        @(posedge clk); #1;

        issue(5'd15, 1000, 7, 5'd8, 0);
        repeat (9) @(posedge clk);
        #1 kill = 1;
        @(posedge clk); #1 kill = 0;
        q.delete(q.size() - 1);
        @(negedge clk);
        chk("kill_busy_ready", in_ready, 1);
        chk("kill_busy_valid", out_valid, 0);
        repeat (40) @(negedge clk);
        @(posedge clk); #1;

        issue(5'd10, 12345, 678, 5'd9, 0);
        repeat (5) @(posedge clk);
        #1 reset = 0;
        if (q.size() != 0) q.delete(q.size() - 1);
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        chk("mid_rst_out", out, 0);
        chk("mid_rst_tag", tag_out, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_illegal", illegal, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        issue(5'd20, 5, 6, 5'd10, 0);
        issue(5'd31, 9, 9, 5'd11, 0);
        drain();

        for (int i = 0; i < 300; i++) begin
            o = 5'($urandom_range(0, 23));
            a = $urandom;
            b = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) b = 0;
            if (r == 1) begin a = 32'h8000_0000; b = '1; end
            if (r == 2) b = $urandom_range(0, 40);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
            issue(o, a, b, 5'($urandom), 1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
